// File: rtl/secded_retx_buffer.sv
// Go-back-N retransmit buffer: holds SECDED codewords until ACKed and replays from the
// oldest unacknowledged flit on NACK or timeout. Optional stats: define RETX_STATS_EN.
module secded_retx_buffer #(
  parameter int WIDTH   = 12,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             rsp_valid,
  input  logic             rsp_ack,
  output logic             protocol_err,
  output logic [7:0]       retx_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [0:0] RUN    = 1'b0;
  localparam logic [0:0] REWIND = 1'b1;

  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, snd_ptr_q, snd_ptr_d, ack_ptr_q, ack_ptr_d;
  logic [0:0]    state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;

  logic [PW-1:0] occupancy, outstanding;
  logic wr_fire, snd_fire, has_out, ack_ev, nack_ev, timeout, replay;

  assign occupancy   = wr_ptr_q - ack_ptr_q;
  assign outstanding = snd_ptr_q - ack_ptr_q;
  assign has_out     = (outstanding != '0);

  assign in_ready  = (occupancy != PW'(DEPTH));
  assign out_valid = (state_q == RUN) && (snd_ptr_q != wr_ptr_q);
  assign out_data  = mem_q[snd_ptr_q[AW-1:0]];

  assign wr_fire  = in_valid && in_ready;
  assign snd_fire = out_valid && out_ready;
  assign ack_ev   = rsp_valid && rsp_ack && has_out;
  assign nack_ev  = rsp_valid && !rsp_ack && has_out;
  assign timeout  = has_out && (tmo_q == TW'(TIMEOUT - 1));
  // NACK and timeout on the same edge collapse into one replay event
  assign replay   = nack_ev || timeout;

  always_comb begin
    mem_d = mem_q;
    if (wr_fire) mem_d[wr_ptr_q[AW-1:0]] = in_data;

    wr_ptr_d = wr_ptr_q;
    if (wr_fire) wr_ptr_d = wr_ptr_q + PW'(1);

    ack_ptr_d = ack_ptr_q;
    if (ack_ev) ack_ptr_d = ack_ptr_q + PW'(1);

    // Rewind to the post-ACK oldest slot so a coincident ACK is never replayed
    snd_ptr_d = snd_ptr_q;
    if (replay)        snd_ptr_d = ack_ptr_d;
    else if (snd_fire) snd_ptr_d = snd_ptr_q + PW'(1);

    state_d = replay ? REWIND : RUN;

    tmo_d = tmo_q + TW'(1);
    if (rsp_valid || !has_out || timeout) tmo_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q     <= '0;
      wr_ptr_q  <= '0;
      snd_ptr_q <= '0;
      ack_ptr_q <= '0;
      state_q   <= RUN;
      tmo_q     <= '0;
    end else begin
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      snd_ptr_q <= snd_ptr_d;
      ack_ptr_q <= ack_ptr_d;
      state_q   <= state_d;
      tmo_q     <= tmo_d;
    end
  end

`ifdef RETX_STATS_EN
  logic [7:0] retx_q, retx_d;
  logic       perr_q, perr_d;

  always_comb begin
    retx_d = retx_q;
    if (replay && (retx_q != 8'hFF)) retx_d = retx_q + 8'd1;
    perr_d = perr_q || (rsp_valid && !has_out);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      retx_q <= '0;
      perr_q <= 1'b0;
    end else begin
      retx_q <= retx_d;
      perr_q <= perr_d;
    end
  end

  assign retx_count   = retx_q;
  assign protocol_err = perr_q;
`else
  assign retx_count   = 8'd0;
  assign protocol_err = 1'b0;
`endif
endmodule

// File: tb/tb_secded_retx_buffer.sv
// Directed bench for secded_retx_buffer: main instance at TIMEOUT=64, second at TIMEOUT=2.
module tb_secded_retx_buffer;
`ifdef RETX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, out_valid, out_ready, rsp_valid, rsp_ack, protocol_err;
  logic [11:0] in_data, out_data;
  logic [7:0]  retx_count;

  logic        in_valid2, in_ready2, out_valid2, out_ready2, rsp_valid2, rsp_ack2, protocol_err2;
  logic [11:0] in_data2, out_data2;
  logic [7:0]  retx_count2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  secded_retx_buffer #(.WIDTH(12), .DEPTH(4), .TIMEOUT(64)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .rsp_valid(rsp_valid), .rsp_ack(rsp_ack),
    .protocol_err(protocol_err), .retx_count(retx_count)
  );

  secded_retx_buffer #(.WIDTH(12), .DEPTH(4), .TIMEOUT(2)) dut2 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
    .rsp_valid(rsp_valid2), .rsp_ack(rsp_ack2),
    .protocol_err(protocol_err2), .retx_count(retx_count2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++;
    if ({in_ready, out_valid, out_data} !== {1'b1, 1'b0, 12'h000}) begin
      errors++;
      $display("FAIL reset_outputs got rdy=%b vld=%b data=%h exp rdy=1 vld=0 data=000", in_ready, out_valid, out_data);
    end
    checks++;
    if ({protocol_err, retx_count} !== 9'h000) begin
      errors++;
      $display("FAIL reset_stats got perr=%b retx=%0d exp 0 0", protocol_err, retx_count);
    end
  endtask

  task automatic test_in_order();
    logic [11:0] v [3];
    v[0] = 12'hA5C; v[1] = 12'h3F1; v[2] = 12'h0E7;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = v[i];
      tick();
      checks++;
      if ({out_valid, out_data} !== {1'b1, v[i]}) begin
        errors++;
        $display("FAIL in_order_%0d got vld=%b data=%h exp vld=1 data=%h", i, out_valid, out_data, v[i]);
      end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL in_order_drained got vld=%b exp 0", out_valid);
    end
    rsp_valid = 1'b1; rsp_ack = 1'b1;
    repeat (3) tick();
    rsp_valid = 1'b0;
    out_ready = 1'b0;
    checks++;
    if ({in_ready, protocol_err} !== 2'b10) begin
      errors++;
      $display("FAIL in_order_acked got rdy=%b perr=%b exp rdy=1 perr=0", in_ready, protocol_err);
    end
  endtask

  task automatic test_fill();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 12'h101 + 12'(i);
      tick();
      checks++;
      if (in_ready !== (i < 3)) begin
        errors++;
        $display("FAIL fill_ready_%0d got %b exp %b", i, in_ready, (i < 3));
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    rsp_valid = 1'b1; rsp_ack = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL fill_ready_same_cycle got %b exp 0", in_ready);
    end
    tick();
    rsp_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL fill_ready_next_cycle got %b exp 1", in_ready);
    end
    in_valid = 1'b1; in_data = 12'h105;
    tick();
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL fill_refull got %b exp 0", in_ready);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({out_valid, out_data} !== {1'b1, 12'h102 + 12'(i)}) begin
        errors++;
        $display("FAIL fill_drain_%0d got vld=%b data=%h exp vld=1 data=%h", i, out_valid, out_data, 12'h102 + 12'(i));
      end
      tick();
    end
    out_ready = 1'b0;
    rsp_valid = 1'b1; rsp_ack = 1'b1;
    repeat (4) tick();
    rsp_valid = 1'b0;
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL fill_empty got rdy=%b vld=%b exp rdy=1 vld=0", in_ready, out_valid);
    end
  endtask

  task automatic test_nack();
    logic [11:0] v [3];
    v[0] = 12'h111; v[1] = 12'h222; v[2] = 12'h333;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = v[i];
      tick();
    end
    in_valid = 1'b0;
    tick();
    rsp_valid = 1'b1; rsp_ack = 1'b1;
    tick();
    rsp_ack = 1'b0;
    tick();
    rsp_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL nack_rewind_gap got vld=%b exp 0", out_valid);
    end
    for (int i = 1; i < 3; i++) begin
      tick();
      checks++;
      if ({out_valid, out_data} !== {1'b1, v[i]}) begin
        errors++;
        $display("FAIL nack_replay_%0d got vld=%b data=%h exp vld=1 data=%h", i, out_valid, out_data, v[i]);
      end
    end
    tick();
    checks++;
    if ({out_valid, retx_count} !== {1'b0, (STATS ? 8'd1 : 8'd0)}) begin
      errors++;
      $display("FAIL nack_retx got vld=%b retx=%0d exp vld=0 retx=%0d", out_valid, retx_count, (STATS ? 1 : 0));
    end
    rsp_valid = 1'b1; rsp_ack = 1'b1;
    repeat (2) tick();
    rsp_valid = 1'b0;
  endtask

  task automatic test_timeout();
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 12'h5A5;
    tick();
    in_valid = 1'b0;
    tick();
    repeat (63) tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early got vld=%b exp 0", out_valid);
    end
    tick();
    tick();
    checks++;
    if ({out_valid, out_data} !== {1'b1, 12'h5A5}) begin
      errors++;
      $display("FAIL timeout_replay got vld=%b data=%h exp vld=1 data=5a5", out_valid, out_data);
    end
    checks++;
    if (retx_count !== (STATS ? 8'd2 : 8'd0)) begin
      errors++;
      $display("FAIL timeout_retx got %0d exp %0d", retx_count, (STATS ? 2 : 0));
    end
    tick();
    rsp_valid = 1'b1; rsp_ack = 1'b1;
    tick();
    rsp_valid = 1'b0;
    out_ready = 1'b0;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL timeout_acked got vld=%b rdy=%b exp vld=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic test_timeout_short();
    logic [8:1] exp_vld;
    logic       bad;
    exp_vld = 8'b0100_0100;  // replay visible after edges N+3 and N+7
    bad = 1'b0;
    out_ready2 = 1'b1;
    in_valid2 = 1'b1; in_data2 = 12'hC3C;
    tick();
    in_valid2 = 1'b0;
    tick();
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (out_valid2 !== exp_vld[k] || (exp_vld[k] && out_data2 !== 12'hC3C)) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL timeout2_repeat got bad=%b exp bad=0 (vld pattern after send %b)", bad, exp_vld);
    end
    rsp_valid2 = 1'b1; rsp_ack2 = 1'b1;
    tick();
    rsp_valid2 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (out_valid2 !== 1'b0) bad = 1'b1;
    end
    checks++;
    if ({bad, retx_count2} !== {1'b0, (STATS ? 8'd2 : 8'd0)}) begin
      errors++;
      $display("FAIL timeout2_stop got bad=%b retx=%0d exp bad=0 retx=%0d", bad, retx_count2, (STATS ? 2 : 0));
    end
    out_ready2 = 1'b0;
  endtask

  task automatic test_protocol_err();
    rsp_valid = 1'b1; rsp_ack = 1'b1;
    tick();
    rsp_valid = 1'b0;
    checks++;
    if ({protocol_err, in_ready, out_valid} !== {STATS, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL perr_set got perr=%b rdy=%b vld=%b exp perr=%b rdy=1 vld=0", protocol_err, in_ready, out_valid, STATS);
    end
    in_valid = 1'b1; in_data = 12'h777;
    tick();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, out_data} !== {1'b1, 12'h777}) begin
      errors++;
      $display("FAIL perr_ptrs got vld=%b data=%h exp vld=1 data=777", out_valid, out_data);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    rsp_valid = 1'b1; rsp_ack = 1'b1;
    tick();
    rsp_valid = 1'b0;
    checks++;
    if ({protocol_err, retx_count} !== {STATS, (STATS ? 8'd2 : 8'd0)}) begin
      errors++;
      $display("FAIL perr_sticky got perr=%b retx=%0d exp perr=%b retx=%0d", protocol_err, retx_count, STATS, (STATS ? 2 : 0));
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 12'hAAA;
    tick();
    in_data = 12'hBBB;
    tick();
    in_valid = 1'b0;
    rsp_valid = 1'b1; rsp_ack = 1'b0;  // NACK lands on the edge that sends BBB
    tick();
    rsp_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_rewind got vld=%b exp 0", out_valid);
    end
    tick();
    checks++;
    if ({out_valid, out_data} !== {1'b1, 12'hAAA}) begin
      errors++;
      $display("FAIL b2b_replay0 got vld=%b data=%h exp vld=1 data=aaa", out_valid, out_data);
    end
    tick();
    checks++;
    if ({out_valid, out_data, retx_count} !== {1'b1, 12'hBBB, (STATS ? 8'd3 : 8'd0)}) begin
      errors++;
      $display("FAIL b2b_replay1 got vld=%b data=%h retx=%0d exp vld=1 data=bbb retx=%0d", out_valid, out_data, retx_count, (STATS ? 3 : 0));
    end
    tick();
    out_ready = 1'b0;
    rsp_valid = 1'b1; rsp_ack = 1'b1;
    repeat (2) tick();
    rsp_valid = 1'b0;
  endtask

  task automatic test_wrap();
    logic [11:0] d;
    int          bad_cnt;
    bad_cnt = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      d = 12'((i * 12'h155) ^ 12'h0A3);
      in_valid = 1'b1; in_data = d;
      tick();
      in_valid = 1'b0;
      if (out_valid !== 1'b1 || out_data !== d) bad_cnt++;
      tick();
      rsp_valid = 1'b1; rsp_ack = 1'b1;
      tick();
      rsp_valid = 1'b0;
    end
    out_ready = 1'b0;
    checks++;
    if (bad_cnt !== 0) begin
      errors++;
      $display("FAIL wrap_integrity got %0d bad flits exp 0", bad_cnt);
    end
    checks++;
    if ({in_ready, out_valid, protocol_err} !== {1'b1, 1'b0, STATS}) begin
      errors++;
      $display("FAIL wrap_end got rdy=%b vld=%b perr=%b exp rdy=1 vld=0 perr=%b", in_ready, out_valid, protocol_err, STATS);
    end
  endtask

  task automatic test_reset_mid();
    logic bad;
    bad = 1'b0;
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 12'hDEF;
    tick();
    in_data = 12'h123;
    tick();
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({in_ready, out_valid, out_data, protocol_err, retx_count} !== {1'b1, 1'b0, 12'h000, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL reset_mid got rdy=%b vld=%b data=%h perr=%b retx=%0d exp 1 0 000 0 0", in_ready, out_valid, out_data, protocol_err, retx_count);
    end
    for (int k = 0; k < 70; k++) begin
      tick();
      if (out_valid !== 1'b0 || retx_count !== 8'd0) bad = 1'b1;
    end
    out_ready = 1'b0;
    checks++;
    if (bad !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_replay got replay=%b exp 0", bad);
    end
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0; rsp_valid = 1'b0; rsp_ack = 1'b0;
    in_valid2 = 1'b0; in_data2 = '0; out_ready2 = 1'b0; rsp_valid2 = 1'b0; rsp_ack2 = 1'b0;
    test_reset();
    test_in_order();
    test_fill();
    test_nack();
    test_timeout();
    test_timeout_short();
    test_protocol_err();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
